pipe_word_assembler: RTL and testbench

//  Builds complete MSG_W-bit request messages from a stream of WORD_W-bit words arriving from the host link.

---
 rtl/pipe_word_assembler.sv | 133 +++++++++++++
 tb/tb_pipe_word_assembler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_word_assembler.sv
// pipe_word_assembler: assembles MSG_W-bit request messages from a stream of
// WORD_W-bit link words and offers each finished message on a pipe enq port.
//
// Message layout (MSB first): {tag[TAG_W], len[TAG_W], payload (left-aligned)}.
// The first word of every message is the header {tag, len}. Messages with more
// than MAX_WORDS payload words are consumed and dropped, and counted in err_count.
//
// Ports
//   CLK            in   clock
//   nRST           in   synchronous reset, active-high
//   in_enq__ENA    in   input word valid (only while in_enq__RDY)
//   in_enq_v       in   input word
//   in_enq__RDY    out  assembler can take a word this cycle
//   pipe_enq__ENA  out  message transfer this cycle
//   pipe_enq_v     out  assembled message (zero unless a message is held)
//   pipe_enq__RDY  in   downstream can take a message
//   err_count      out  oversize messages dropped, saturating at 255
//   busy           out  message in progress or waiting for output
module pipe_word_assembler #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned TAG_W     = 16,
  parameter int unsigned MSG_W     = 144,
  parameter int unsigned MAX_WORDS = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_enq__ENA,
  input  logic [WORD_W-1:0] in_enq_v,
  output logic              in_enq__RDY,
  output logic              pipe_enq__ENA,
  output logic [MSG_W-1:0]  pipe_enq_v,
  input  logic              pipe_enq__RDY,
  output logic [7:0]        err_count,
  output logic              busy
);

  localparam int unsigned HDR_W   = 2 * TAG_W;
  localparam int unsigned PAY_TOP = MSG_W - HDR_W - 1;
  localparam int unsigned LOW_W   = MSG_W - WORD_W;
  localparam int unsigned IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    EMIT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [MSG_W-1:0]   msg_buf;
  logic [IDX_W-1:0]   word_idx;
  logic [TAG_W-1:0]   remaining;
  logic [TAG_W-1:0]   hdr_len;
  logic               word_xfer;
  logic               oversize;

  // Link is only stalled while a finished message waits for the demux.
  assign in_enq__RDY = (state != EMIT);
  assign busy        = (state != IDLE);
  assign word_xfer   = in_enq__ENA & in_enq__RDY;
  assign hdr_len     = in_enq_v[TAG_W-1:0];
  assign oversize    = (hdr_len > TAG_W'(MAX_WORDS));

  // State register.
  always_ff @(posedge CLK) begin
    if (nRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and message-port outputs.
  always_comb begin
    state_nxt     = state;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v    = '0;
    case (state)
      IDLE: begin
        if (word_xfer) begin
          if (hdr_len == '0) state_nxt = EMIT;
          else if (oversize) state_nxt = DRAIN;
          else               state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (word_xfer && remaining == TAG_W'(1)) state_nxt = EMIT;
      end
      DRAIN: begin
        if (word_xfer && remaining == TAG_W'(1)) state_nxt = IDLE;
      end
      EMIT: begin
        pipe_enq_v    = msg_buf;
        pipe_enq__ENA = pipe_enq__RDY;
        if (pipe_enq__RDY) state_nxt = IDLE;
      end
    endcase
  end

  // Message buffer, word index, remaining count and drop counter.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      msg_buf   <= '0;
      word_idx  <= '0;
      remaining <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (word_xfer) begin
            // Header lands in the tag/len fields; payload area cleared.
            msg_buf   <= {in_enq_v, {LOW_W{1'b0}}};
            remaining <= hdr_len;
            word_idx  <= '0;
            if (oversize && err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        COLLECT: begin
          if (word_xfer) begin
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
              if (word_idx == IDX_W'(i)) msg_buf[PAY_TOP - WORD_W*i -: WORD_W] <= in_enq_v;
            end
            word_idx  <= word_idx + IDX_W'(1);
            remaining <= remaining - TAG_W'(1);
          end
        end
        DRAIN: begin
          if (word_xfer) remaining <= remaining - TAG_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_word_assembler.sv
// Self-checking bench for pipe_word_assembler: a per-cycle vector table for the
// basic message shapes and back-pressure, plus hand sequences for drop, reset,
// back-to-back streaming and err_count saturation.
module tb_pipe_word_assembler;

  logic         clk;
  logic         rst;
  logic         in_ena;
  logic [31:0]  in_v;
  logic         in_rdy;
  logic         out_ena;
  logic [143:0] out_v;
  logic         out_rdy;
  logic [7:0]   err_count;
  logic         busy;

  int errors;
  int checks;

  pipe_word_assembler dut (
    .CLK           (clk),
    .nRST          (rst),
    .in_enq__ENA   (in_ena),
    .in_enq_v      (in_v),
    .in_enq__RDY   (in_rdy),
    .pipe_enq__ENA (out_ena),
    .pipe_enq_v    (out_v),
    .pipe_enq__RDY (out_rdy),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ena;
    logic [31:0]  v;
    logic         rdy;
    logic         e_inrdy;
    logic         e_ena;
    logic [143:0] e_v;
    logic [7:0]   e_err;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic ena, input logic [31:0] v, input logic rdy,
                              input logic e_inrdy, input logic e_ena, input logic [143:0] e_v,
                              input logic [7:0] e_err, input logic e_busy);
    vec_t t;
    t.rst = r; t.ena = ena; t.v = v; t.rdy = rdy;
    t.e_inrdy = e_inrdy; t.e_ena = e_ena; t.e_v = e_v; t.e_err = e_err; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic e_inrdy, input logic e_ena,
                         input logic [143:0] e_v, input logic [7:0] e_err, input logic e_busy);
    chk({name, ".in_rdy"}, 144'(in_rdy), 144'(e_inrdy));
    chk({name, ".ena"},    144'(out_ena), 144'(e_ena));
    chk({name, ".v"},      out_v, e_v);
    chk({name, ".err"},    144'(err_count), 144'(e_err));
    chk({name, ".busy"},   144'(busy), 144'(e_busy));
  endtask

  // Drive inputs just after the falling edge; outputs are then sampled mid-cycle.
  task automatic apply(input logic r, input logic ena, input logic [31:0] v, input logic rdy);
    @(negedge clk);
    rst = r; in_ena = ena; in_v = v; out_rdy = rdy;
    #1;
  endtask

  localparam logic [31:0] WA = 32'hA1A2A3A4;
  localparam logic [31:0] WB = 32'hB1B2B3B4;
  localparam logic [31:0] WC = 32'hC1C2C3C4;

  initial begin
    logic [143:0] m1, m2, m3, m4, m5;
    logic [31:0]  words[8];
    int           wi;
    int           pulses;

    errors = 0; checks = 0;
    clk = 1'b0; rst = 1'b1; in_ena = 1'b0; in_v = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);

    m1 = {16'h0000, 16'h0001, 32'hDEADBEEF, 80'h0};
    m2 = {16'h0002, 16'h0000, 112'h0};
    m3 = {16'h0001, 16'h0003, WA, WB, WC, 16'h0};

    // Reset state.
    vecs.push_back(mk(0, 0, 32'h0, 0,        1, 0, 144'h0, 8'd0, 0));
    // len=1: header, word, message two cycles after the header.
    vecs.push_back(mk(0, 1, 32'h0000_0001, 1, 1, 0, 144'h0, 8'd0, 0));
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 1,  1, 0, 144'h0, 8'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1,        0, 1, m1,     8'd0, 1));
    // len=0: message the cycle after the header.
    vecs.push_back(mk(0, 1, 32'h0002_0000, 1, 1, 0, 144'h0, 8'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1,        0, 1, m2,     8'd0, 1));
    // len=MAX_WORDS with the demux stalled for five cycles.
    vecs.push_back(mk(0, 1, 32'h0001_0003, 0, 1, 0, 144'h0, 8'd0, 0));
    vecs.push_back(mk(0, 1, WA, 0,           1, 0, 144'h0, 8'd0, 1));
    vecs.push_back(mk(0, 1, WB, 0,           1, 0, 144'h0, 8'd0, 1));
    vecs.push_back(mk(0, 1, WC, 0,           1, 0, 144'h0, 8'd0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, m3, 8'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1,        0, 1, m3,     8'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0, 1,        1, 0, 144'h0, 8'd0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].ena, vecs[i].v, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_inrdy, vecs[i].e_ena, vecs[i].e_v,
              vecs[i].e_err, vecs[i].e_busy);
    end

    // Oversize (len=5) message is drained silently, then a valid len=1 message.
    apply(0, 1, 32'h00AB_0005, 1);
    chk_all("drop.hdr", 1, 0, 144'h0, 8'd0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 32'h5000_0000 + 32'(i), 1);
      chk_all($sformatf("drop.w%0d", i), 1, 0, 144'h0, 8'd1, 1);
    end
    m4 = {16'h0007, 16'h0001, 32'h12345678, 80'h0};
    apply(0, 1, 32'h0007_0001, 1);
    chk_all("after_drop.hdr", 1, 0, 144'h0, 8'd1, 0);
    apply(0, 1, 32'h12345678, 1);
    chk_all("after_drop.w0", 1, 0, 144'h0, 8'd1, 1);
    apply(0, 0, 32'h0, 1);
    chk_all("after_drop.emit", 0, 1, m4, 8'd1, 1);

    // Reset in the middle of a len=3 message discards it and clears err_count.
    apply(0, 1, 32'h0001_0003, 1);
    apply(0, 1, WA, 1);
    apply(0, 1, WB, 1);
    apply(1, 0, 32'h0, 1);
    apply(0, 0, 32'h0, 1);
    chk_all("post_reset", 1, 0, 144'h0, 8'd0, 0);
    apply(0, 0, 32'h0, 1);
    chk_all("post_reset.idle", 1, 0, 144'h0, 8'd0, 0);
    m5 = {16'h0009, 16'h0001, 32'hCAFEF00D, 80'h0};
    apply(0, 1, 32'h0009_0001, 1);
    apply(0, 1, 32'hCAFEF00D, 1);
    chk_all("fresh.w0", 1, 0, 144'h0, 8'd0, 1);
    apply(0, 0, 32'h0, 1);
    chk_all("fresh.emit", 0, 1, m5, 8'd0, 1);

    // Back-to-back len=1 messages with input valid whenever accepted.
    for (int m = 0; m < 4; m++) begin
      words[2*m]   = 32'h0001_0001 + 32'(m << 16);
      words[2*m+1] = 32'hC0DE_0000 + 32'(m);
    end
    wi = 0; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rst = 1'b0; out_rdy = 1'b1;
      #1;
      if (in_rdy && wi < 8) begin
        in_ena = 1'b1; in_v = words[wi]; wi++;
      end else begin
        in_ena = 1'b0; in_v = '0;
      end
      #1;
      if (out_ena) pulses++;
      chk($sformatf("b2b.c%0d.ena", c), 144'(out_ena), 144'(c % 3 == 2));
      if (c % 3 == 2)
        chk($sformatf("b2b.c%0d.v", c), out_v,
            {16'(c / 3 + 1), 16'h0001, 32'hC0DE_0000 + 32'(c / 3), 80'h0});
    end
    chk("b2b.pulses", 144'(pulses), 144'(4));
    chk("b2b.words", 144'(wi), 144'(8));

    // err_count saturates at 255 with len=MAX_WORDS+1 messages.
    for (int n = 0; n < 257; n++) begin
      apply(0, 1, 32'h0000_0004, 1);
      chk($sformatf("sat.n%0d.err", n), 144'(err_count), 144'((n > 255) ? 255 : n));
      for (int i = 0; i < 4; i++) begin
        apply(0, 1, 32'(i), 1);
        if (out_ena) chk($sformatf("sat.n%0d.noena", n), 144'(out_ena), 144'(0));
      end
    end
    apply(0, 0, 32'h0, 1);
    chk_all("sat.final", 1, 0, 144'h0, 8'd255, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
